// File: rtl/jtag_uart_bridge.sv
// jtag_uart_bridge: system-clock side of the JTAG virtual UART.
// Host word is synchronised and filtered; RX/TX FIFOs use 4-bit seq/ack numbers.
module jtag_uart_bridge #(
    parameter int FIFO_DEPTH  = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] jtag_tx_in,
    output logic [31:0] uart_state_out,
    output logic [7:0]  rx_data,
    output logic        rx_valid,
    input  logic        rx_ready,
    input  logic [7:0]  tx_data,
    input  logic        tx_valid,
    output logic        tx_ready
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;

    logic [31:0]   r_sync [SYNC_STAGES];
    logic [31:0]   r_hold;

    logic [7:0]    r_rx_mem [FIFO_DEPTH];
    logic [AW-1:0] r_rx_wp;
    logic [AW-1:0] r_rx_rp;
    logic [CW-1:0] r_rx_cnt;
    logic [3:0]    r_rx_ack;

    logic [7:0]    r_tx_mem [FIFO_DEPTH];
    logic [AW-1:0] r_tx_wp;
    logic [AW-1:0] r_tx_rp;
    logic [CW-1:0] r_tx_cnt;
    logic [3:0]    r_tx_seq;

    logic [31:0]   r_state;

    logic [31:0]   w_word;
    logic          w_stable;
    logic          w_rx_empty;
    logic          w_rx_full;
    logic          w_rx_push;
    logic          w_rx_pop;
    logic          w_tx_pend;
    logic          w_tx_full;
    logic          w_tx_push;
    logic          w_tx_pop;
    logic [7:0]    w_tx_head;

    // A word counts only when two consecutive samples agree on every bit,
    // which rejects words caught mid-update across the clock boundary.
    assign w_word   = r_sync[SYNC_STAGES-1];
    assign w_stable = (w_word == r_hold);

    assign w_rx_empty = (r_rx_cnt == '0);
    assign w_rx_full  = (r_rx_cnt == CW'(FIFO_DEPTH));
    assign rx_valid   = !w_rx_empty && !reset;
    assign rx_data    = rx_valid ? r_rx_mem[r_rx_rp] : 8'h00;
    assign w_rx_pop   = rx_valid && rx_ready;
    assign w_rx_push  = w_stable && w_word[8]
                     && (w_word[15:12] != r_rx_ack)
                     && (!w_rx_full || w_rx_pop);

    assign w_tx_pend = (r_tx_cnt != '0);
    assign w_tx_full = (r_tx_cnt == CW'(FIFO_DEPTH));
    assign tx_ready  = !w_tx_full && !reset;
    assign w_tx_push = tx_valid && tx_ready;
    assign w_tx_pop  = w_stable && w_tx_pend
                    && (w_word[19:16] == r_tx_seq);
    assign w_tx_head = w_tx_pend ? r_tx_mem[r_tx_rp] : 8'h00;

    assign uart_state_out = r_state;

    // Synchroniser chain plus hold register for the stability compare.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < SYNC_STAGES; i++) r_sync[i] <= '0;
            r_hold <= '0;
        end else begin
            r_sync[0] <= jtag_tx_in;
            for (int i = 1; i < SYNC_STAGES; i++) r_sync[i] <= r_sync[i-1];
            r_hold <= r_sync[SYNC_STAGES-1];
        end
    end

    // RX storage: written only on an accepted host byte.
    always_ff @(posedge clk) begin
        if (w_rx_push) r_rx_mem[r_rx_wp] <= w_word[7:0];
    end

    // RX pointers, occupancy and the acknowledge number echoed to the host.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_rx_wp  <= '0;
            r_rx_rp  <= '0;
            r_rx_cnt <= '0;
            r_rx_ack <= 4'd0;
        end else begin
            if (w_rx_push) begin
                r_rx_wp  <= r_rx_wp + AW'(1);
                r_rx_ack <= w_word[15:12];
            end
            if (w_rx_pop) r_rx_rp <= r_rx_rp + AW'(1);
            if (w_rx_push && !w_rx_pop) r_rx_cnt <= r_rx_cnt + CW'(1);
            else if (!w_rx_push && w_rx_pop) r_rx_cnt <= r_rx_cnt - CW'(1);
        end
    end

    // TX storage: written on a CPU handshake.
    always_ff @(posedge clk) begin
        if (w_tx_push) r_tx_mem[r_tx_wp] <= tx_data;
    end

    // TX pointers, occupancy and the sequence number the host must echo.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_tx_wp  <= '0;
            r_tx_rp  <= '0;
            r_tx_cnt <= '0;
            r_tx_seq <= 4'd1;
        end else begin
            if (w_tx_push) r_tx_wp <= r_tx_wp + AW'(1);
            if (w_tx_pop) begin
                r_tx_rp  <= r_tx_rp + AW'(1);
                r_tx_seq <= r_tx_seq + 4'd1;
            end
            if (w_tx_push && !w_tx_pop) r_tx_cnt <= r_tx_cnt + CW'(1);
            else if (!w_tx_push && w_tx_pop) r_tx_cnt <= r_tx_cnt - CW'(1);
        end
    end

    // Host-visible word, all fields registered together on one edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= 32'hA500_1000;
        end else begin
            r_state <= {8'hA5, 3'b000, w_rx_full, r_rx_ack,
                        r_tx_seq, 3'b000, w_tx_pend, w_tx_head};
        end
    end

endmodule

// File: doc/jtag_uart_bridge.md
# jtag_uart_bridge

System-clock end of the JTAG virtual UART. It takes the host-to-target word written over JTAG (quasi-static, tck domain) and turns it into a byte stream with a valid/ready handshake for the CPU. It also queues CPU output bytes and publishes them in the word the host captures on the UART opcode. All sequencing uses 4-bit sequence/acknowledge numbers, so the host side never needs handshake strobes.

## Interface
- `FIFO_DEPTH`, 8: entries in each of the RX and TX FIFOs; power of two, 2..64.
- `SYNC_STAGES`, 2: synchronizer flops on `jtag_tx_in`, minimum 2.
- `clk`  in  1  system clock.
- `reset`  in  1  synchronous, active-high reset.
- `jtag_tx_in`  in  32  host word from the tck domain, asynchronous to `clk`:
  - [7:0] byte
  - [8] byte_valid
  - [15:12] rx_seq
  - [19:16] tx_ack_seq
  - all other bits ignored
- `uart_state_out`  out  32  registered word captured by the host:
  - [7:0] TX head byte
  - [8] tx_pending
  - [15:12] tx_seq
  - [19:16] rx_ack_seq
  - [20] rx_full
  - [31:24] 8'hA5
  - all other bits 0
- `rx_data`  out  8  byte to CPU.
- `rx_valid`  out  1  `rx_data` valid.
- `rx_ready`  in  1  CPU accepts the byte.
- `tx_data`  in  8  byte from CPU.
- `tx_valid`  in  1  `tx_data` valid.
- `tx_ready`  out  1  TX FIFO can accept.

## Operation
- Input capture:
  - `jtag_tx_in` passes through `SYNC_STAGES` flops, then one hold register.
  - The word is "stable" when the last sync stage equals the hold register, across all 32 bits. This filters multibit skew.
  - Only a stable word is acted on.
- RX accept:
  - Accept when the word is stable, byte_valid=1, rx_seq != rx_ack_seq, and the RX FIFO is not full (or is full with a CPU pop in the same cycle).
  - On accept: push the byte and set rx_ack_seq to rx_seq, in the same cycle.
  - If the FIFO is full, ignore the word; rx_ack_seq stays unchanged and the host retries.
  - If byte_valid=0, ignore the word, even if its sequence number is new.
- RX to CPU: FIFO head drives `rx_data`. `rx_valid` = FIFO not empty. Pop on `rx_valid && rx_ready`.
- TX from CPU: `tx_ready` = TX FIFO not full, with no bypass on pop. Push on `tx_valid && tx_ready`.
- TX to host:
  - tx_pending = TX FIFO not empty. TX head byte = FIFO head.
  - Pop when the word is stable, tx_pending=1, and tx_ack_seq == tx_seq; tx_seq increments mod 16 in the same cycle.
  - The host acknowledges by echoing tx_seq. A stale ack equal to an old value never matches, because tx_seq only advances on a match.
- rx_full = RX FIFO count == `FIFO_DEPTH`.
- FIFO counts are `$clog2(FIFO_DEPTH)+1` bits wide; pointers wrap naturally.
- A push and a pop on the same FIFO in the same cycle leave the count unchanged.

## Timing
- Reset values:
  - `rx_valid`=0, `rx_data`=0, `tx_ready`=0 during reset and 1 on the first cycle after it.
  - rx_ack_seq=0, tx_seq=1.
  - `uart_state_out` = 32'hA500_1000.
  - Both FIFOs empty; sync and hold registers 0.
- Host word latency: a new `jtag_tx_in` held constant from before edge 0 reaches the last sync stage at edge `SYNC_STAGES`-1 and the hold register at edge `SYNC_STAGES`. It is stable and accepted at edge `SYNC_STAGES`+1. `rx_valid` is high after that edge (3 cycles at default).
- `uart_state_out` reflects FIFO state and seq numbers with one cycle of registration delay. All 32 bits update on the same edge. The host treats a capture as valid only if two consecutive captures match.
- Reset asserted mid-operation: both FIFOs flush, seq numbers return to their reset values, and an in-flight word is discarded. The host must re-sync by observing tx_seq=1 and rx_ack_seq=0.

## Test plan
- Reset, then hold `jtag_tx_in`=0 -> `rx_valid` stays 0 and `uart_state_out`=32'hA500_1000 indefinitely.
- RX path:
  - Stimulus: write byte 0x41 with valid, rx_seq=1; `rx_ready`=1.
  - Required: `rx_data`=0x41 and `rx_valid` high for exactly one cycle, 3 cycles after the change; rx_ack_seq=1.
  - Then re-present the same word -> no second push.
- RX overflow:
  - Stimulus: `rx_ready`=0; send 9 words with rx_seq 1..9.
  - Required: after 8, rx_full=1 and rx_ack_seq=8; the 9th is held off.
  - Then one pop -> the 9th is accepted, rx_ack_seq=9.
- TX path:
  - Stimulus: CPU pushes 0x10, 0x20.
  - Required: uart_state_out shows byte 0x10, pending=1, tx_seq=1.
  - Then ack=1 -> shows 0x20 with tx_seq=2.
  - Then ack=2 -> pending=0, tx_seq=3.
  - An ack of 1 re-presented causes no pop.
- TX full: push 8 bytes with no ack -> `tx_ready`=0; a 9th `tx_valid` is not accepted.
- Glitch and reset:
  - Change `jtag_tx_in` bits on alternate cycles -> no accept until the word is held 2 consecutive cycles past sync.
  - Assert reset with both FIFOs half full -> FIFOs empty and registers at reset values the next cycle.
